// File: rtl/lp_arbiter.sv
// Round-robin front end for a shared 2-variable LP engine: collects one problem
// from the granted requester, replays it as a gap-free burst, returns the result.
module lp_arbiter #(
  parameter int BEATS   = 7,
  parameter int TIMEOUT = 2**24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req,
  output logic [1:0]         gnt,
  input  logic [1:0]         src_valid,
  input  logic [11:0]        src_a1,
  input  logic [11:0]        src_a2,
  input  logic [23:0]        src_b,
  output logic               eng_in_valid,
  output logic signed [5:0]  eng_a1,
  output logic signed [5:0]  eng_a2,
  output logic signed [11:0] eng_b,
  input  logic               eng_out_valid,
  input  logic signed [11:0] eng_out_max_value,
  output logic [1:0]         res_valid,
  output logic signed [11:0] res_value,
  output logic               res_err
);

  localparam int          CW       = $clog2(BEATS + 1);
  localparam logic [23:0] WD_LIMIT = 24'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_REPLAY  = 3'd2,
    S_WAIT    = 3'd3,
    S_RESP    = 3'd4,
    S_DRAIN   = 3'd5
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] beat_cnt_r, beat_cnt_s;
  logic [23:0]   wdog_r, wdog_s;
  logic          last_r, last_s;
  logic          owner_r, owner_s;
  logic          err_r, err_s;

  logic [1:0]  gnt_r, gnt_s;
  logic        eiv_r, eiv_s;
  logic [5:0]  ea1_r, ea1_s, ea2_r, ea2_s;
  logic [11:0] eb_r, eb_s;
  logic [1:0]  rv_r, rv_s;
  logic [11:0] rval_r, rval_s;
  logic        rerr_r, rerr_s;

  logic [5:0]  buf_a1_r [BEATS];
  logic [5:0]  buf_a2_r [BEATS];
  logic [11:0] buf_b_r  [BEATS];

  logic        cap_s;
  logic [5:0]  in_a1_s, in_a2_s;
  logic [11:0] in_b_s;

  function automatic logic [1:0] onehot(input logic sel);
    return sel ? 2'b10 : 2'b01;
  endfunction

  // Beat capture qualifier and lane select for the current owner
  always_comb begin
    cap_s   = (state_r == S_COLLECT) && src_valid[owner_r];
    in_a1_s = owner_r ? src_a1[11:6]  : src_a1[5:0];
    in_a2_s = owner_r ? src_a2[11:6]  : src_a2[5:0];
    in_b_s  = owner_r ? src_b[23:12]  : src_b[11:0];
  end

  // Problem buffer; contents are meaningless after reset, so it is not cleared
  always_ff @(posedge clk) begin
    if (cap_s) begin
      buf_a1_r[beat_cnt_r] <= in_a1_s;
      buf_a2_r[beat_cnt_r] <= in_a2_s;
      buf_b_r[beat_cnt_r]  <= in_b_s;
    end
  end

  // Next-state and next-output logic; outputs are computed one cycle ahead
  always_comb begin
    state_s    = state_r;
    beat_cnt_s = beat_cnt_r;
    wdog_s     = wdog_r;
    last_s     = last_r;
    owner_s    = owner_r;
    err_s      = err_r;
    gnt_s      = 2'b00;
    eiv_s      = 1'b0;
    ea1_s      = 6'd0;
    ea2_s      = 6'd0;
    eb_s       = 12'd0;
    rv_s       = 2'b00;
    rval_s     = 12'd0;
    rerr_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (req != 2'b00) begin
          // On a tie the pointer names the last served side, so pick the other
          owner_s    = (req == 2'b11) ? ~last_r : req[1];
          gnt_s      = onehot(owner_s);
          beat_cnt_s = '0;
          state_s    = S_COLLECT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_COLLECT: begin
        if (cap_s && (beat_cnt_r == CW'(BEATS - 1))) begin
          state_s    = S_REPLAY;
          beat_cnt_s = CW'(1);
          eiv_s      = 1'b1;
          ea1_s      = buf_a1_r[0];
          ea2_s      = buf_a2_r[0];
          eb_s       = buf_b_r[0];
        end else if (cap_s) begin
          beat_cnt_s = beat_cnt_r + CW'(1);
          gnt_s      = onehot(owner_r);
        end else begin
          gnt_s = onehot(owner_r);
        end
      end
      S_REPLAY: begin
        if (beat_cnt_r == CW'(BEATS)) begin
          state_s    = S_WAIT;
          beat_cnt_s = '0;
          wdog_s     = 24'd0;
        end else begin
          eiv_s      = 1'b1;
          ea1_s      = buf_a1_r[beat_cnt_r];
          ea2_s      = buf_a2_r[beat_cnt_r];
          eb_s       = buf_b_r[beat_cnt_r];
          beat_cnt_s = beat_cnt_r + CW'(1);
        end
      end
      S_WAIT: begin
        if (eng_out_valid) begin
          err_s   = 1'b0;
          rv_s    = onehot(owner_r);
          rval_s  = eng_out_max_value;
          rerr_s  = 1'b0;
          state_s = S_RESP;
        end else if (wdog_r == WD_LIMIT) begin
          err_s   = 1'b1;
          rv_s    = onehot(owner_r);
          rval_s  = 12'd0;
          rerr_s  = 1'b1;
          state_s = S_RESP;
        end else begin
          wdog_s = wdog_r + 24'd1;
        end
      end
      S_RESP: begin
        last_s  = owner_r;
        state_s = err_r ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (eng_out_valid) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= S_IDLE;
      beat_cnt_r <= '0;
      wdog_r     <= 24'd0;
      last_r     <= 1'b1;
      owner_r    <= 1'b0;
      err_r      <= 1'b0;
      gnt_r      <= 2'b00;
      eiv_r      <= 1'b0;
      ea1_r      <= 6'd0;
      ea2_r      <= 6'd0;
      eb_r       <= 12'd0;
      rv_r       <= 2'b00;
      rval_r     <= 12'd0;
      rerr_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      beat_cnt_r <= beat_cnt_s;
      wdog_r     <= wdog_s;
      last_r     <= last_s;
      owner_r    <= owner_s;
      err_r      <= err_s;
      gnt_r      <= gnt_s;
      eiv_r      <= eiv_s;
      ea1_r      <= ea1_s;
      ea2_r      <= ea2_s;
      eb_r       <= eb_s;
      rv_r       <= rv_s;
      rval_r     <= rval_s;
      rerr_r     <= rerr_s;
    end
  end

  assign gnt          = gnt_r;
  assign eng_in_valid = eiv_r;
  assign eng_a1       = ea1_r;
  assign eng_a2       = ea2_r;
  assign eng_b        = eb_r;
  assign res_valid    = rv_r;
  assign res_value    = rval_r;
  assign res_err      = rerr_r;

endmodule
